line_seg_multi: RTL

LINE_SEG_MULTI -- requirements
Module: line_seg_multi

---
 rtl/line_seg_multi.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/line_seg_multi.sv
// Multi-channel point-on-segment detector: a 3-stage pipeline tests each pixel against N_LINES segments.
// Optional hit counter (cnt_clr / hit_cnt ports) is built when LINE_SEG_HITCNT_EN is defined.
module line_seg_multi #(
    parameter int W       = 21,
    parameter int FRAC    = 10,
    parameter int N_LINES = 4,
    parameter int TH      = 1024,
    localparam int IDXW   = (N_LINES > 1) ? $clog2(N_LINES) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] h_cnt_Q,
    input  logic signed [W-1:0] v_cnt_Q,
    input  logic                vtx_we,
    input  logic [IDXW-1:0]     vtx_idx,
    input  logic signed [W-1:0] vtxA_X,
    input  logic signed [W-1:0] vtxA_Y,
    input  logic signed [W-1:0] vtxB_X,
    input  logic signed [W-1:0] vtxB_Y,
    input  logic [N_LINES-1:0]  line_en,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N_LINES-1:0]  onLine,
    output logic                anyLine,
    output logic [IDXW-1:0]     hitIdx
`ifdef LINE_SEG_HITCNT_EN
    ,
    input  logic                cnt_clr,
    output logic [15:0]         hit_cnt
`endif
);

    localparam logic signed [W-1:0] POS_TH = W'(TH);
    localparam logic signed [W-1:0] NEG_TH = W'(-TH);

    function automatic logic [2*W-1:0] sext(input logic [W-1:0] v);
        return {{W{v[W-1]}}, v};
    endfunction

    // endpoint register file
    logic signed [W-1:0] a_x [N_LINES];
    logic signed [W-1:0] a_y [N_LINES];
    logic signed [W-1:0] b_x [N_LINES];
    logic signed [W-1:0] b_y [N_LINES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_LINES; i++) begin
                a_x[i] <= '0;
                a_y[i] <= '0;
                b_x[i] <= '0;
                b_y[i] <= '0;
            end
        end else if (vtx_we && (int'(vtx_idx) < N_LINES)) begin
            a_x[vtx_idx] <= vtxA_X;
            a_y[vtx_idx] <= vtxA_Y;
            b_x[vtx_idx] <= vtxB_X;
            b_y[vtx_idx] <= vtxB_Y;
        end
    end

    // pipeline flow control: a stage advances when it is empty or its successor advances
    logic v1, v2, v3;
    logic adv1, adv2, adv3;
    logic accept;

    assign adv3      = !v3 || out_ready;
    assign adv2      = !v2 || adv3;
    assign adv1      = !v1 || adv2;
    assign in_ready  = adv1;
    assign accept    = in_valid && in_ready;
    assign out_valid = v3;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            if (adv1) v1 <= accept;
            if (adv2) v2 <= v1;
            if (adv3) v3 <= v2;
        end
    end

    // stage 1: difference vectors and bounding boxes
    logic signed [W-1:0] d1_ap_x [N_LINES];
    logic signed [W-1:0] d1_ap_y [N_LINES];
    logic signed [W-1:0] d1_ab_x [N_LINES];
    logic signed [W-1:0] d1_ab_y [N_LINES];
    logic signed [W-1:0] d1_lo_x [N_LINES];
    logic signed [W-1:0] d1_hi_x [N_LINES];
    logic signed [W-1:0] d1_lo_y [N_LINES];
    logic signed [W-1:0] d1_hi_y [N_LINES];

    always_comb begin
        for (int i = 0; i < N_LINES; i++) begin
            d1_ap_x[i] = h_cnt_Q - a_x[i];
            d1_ap_y[i] = v_cnt_Q - a_y[i];
            d1_ab_x[i] = b_x[i] - a_x[i];
            d1_ab_y[i] = b_y[i] - a_y[i];
            d1_lo_x[i] = (a_x[i] < b_x[i]) ? a_x[i] : b_x[i];
            d1_hi_x[i] = (a_x[i] < b_x[i]) ? b_x[i] : a_x[i];
            d1_lo_y[i] = (a_y[i] < b_y[i]) ? a_y[i] : b_y[i];
            d1_hi_y[i] = (a_y[i] < b_y[i]) ? b_y[i] : a_y[i];
        end
    end

    logic signed [W-1:0] s1_ap_x [N_LINES];
    logic signed [W-1:0] s1_ap_y [N_LINES];
    logic signed [W-1:0] s1_ab_x [N_LINES];
    logic signed [W-1:0] s1_ab_y [N_LINES];
    logic signed [W-1:0] s1_lo_x [N_LINES];
    logic signed [W-1:0] s1_hi_x [N_LINES];
    logic signed [W-1:0] s1_lo_y [N_LINES];
    logic signed [W-1:0] s1_hi_y [N_LINES];
    logic signed [W-1:0] s1_px;
    logic signed [W-1:0] s1_py;
    logic [N_LINES-1:0]  s1_en;

    always_ff @(posedge clk) begin
        if (adv1) begin
            for (int i = 0; i < N_LINES; i++) begin
                s1_ap_x[i] <= d1_ap_x[i];
                s1_ap_y[i] <= d1_ap_y[i];
                s1_ab_x[i] <= d1_ab_x[i];
                s1_ab_y[i] <= d1_ab_y[i];
                s1_lo_x[i] <= d1_lo_x[i];
                s1_hi_x[i] <= d1_hi_x[i];
                s1_lo_y[i] <= d1_lo_y[i];
                s1_hi_y[i] <= d1_hi_y[i];
            end
            s1_px <= h_cnt_Q;
            s1_py <= v_cnt_Q;
            s1_en <= line_en;
        end
    end

    // stage 2: cross product; the box test and enable fold into one bit per channel
    logic signed [2*W-1:0] d2_cross [N_LINES];
    logic [N_LINES-1:0]    d2_seg;

    always_comb begin
        d2_seg = '0;
        for (int i = 0; i < N_LINES; i++) begin
            d2_cross[i] = sext(s1_ab_x[i]) * sext(s1_ap_y[i])
                        - sext(s1_ap_x[i]) * sext(s1_ab_y[i]);
            d2_seg[i]   = s1_en[i]
                        && (s1_px >= s1_lo_x[i]) && (s1_px <= s1_hi_x[i])
                        && (s1_py >= s1_lo_y[i]) && (s1_py <= s1_hi_y[i]);
        end
    end

    logic signed [2*W-1:0] s2_cross [N_LINES];
    logic [N_LINES-1:0]    s2_seg;

    always_ff @(posedge clk) begin
        if (adv2) begin
            for (int i = 0; i < N_LINES; i++) s2_cross[i] <= d2_cross[i];
            s2_seg <= d2_seg;
        end
    end

    // stage 3: scale, strict threshold window, priority encode
    logic signed [W-1:0] d3_c [N_LINES];
    logic [N_LINES-1:0]  d3_hit;
    logic [IDXW-1:0]     d3_idx;

    always_comb begin
        d3_hit = '0;
        d3_idx = '0;
        for (int i = 0; i < N_LINES; i++) begin
            d3_c[i]   = W'(s2_cross[i] >>> FRAC);
            d3_hit[i] = s2_seg[i] && (d3_c[i] > NEG_TH) && (d3_c[i] < POS_TH);
        end
        for (int i = N_LINES - 1; i >= 0; i--) begin
            if (d3_hit[i]) d3_idx = IDXW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            onLine  <= '0;
            anyLine <= 1'b0;
            hitIdx  <= '0;
        end else if (adv3 && v2) begin
            onLine  <= d3_hit;
            anyLine <= |d3_hit;
            hitIdx  <= d3_idx;
        end
    end

`ifdef LINE_SEG_HITCNT_EN
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            hit_cnt <= '0;
        end else if (out_valid && out_ready && anyLine && (hit_cnt != 16'hFFFF)) begin
            hit_cnt <= hit_cnt + 16'd1;
        end
    end
`endif

endmodule
